// File: rtl/sine_sweep_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : sine_sweep_ctrl_if
// Brief    : Sweep request/config and phase-increment output bundle.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface sine_sweep_ctrl_if #(
  parameter int DW      = 12,
  parameter int DWELL_W = 16
);
  logic               start;
  logic               abort;
  logic [DW-1:0]      f_start;
  logic [DW-1:0]      f_stop;
  logic [DW-1:0]      f_step;
  logic [DWELL_W-1:0] dwell;
  logic [DW-1:0]      delta;
  logic               busy;
  logic               done;
  logic               cfg_err;

  modport master (
    output start, abort, f_start, f_stop, f_step, dwell,
    input  delta, busy, done, cfg_err
  );

  modport slave (
    input  start, abort, f_start, f_stop, f_step, dwell,
    output delta, busy, done, cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/sine_sweep_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : sine_sweep_ctrl
// Brief    : Stepped-chirp controller driving the sine generator delta input.
//            Define SWEEP_BIDIR_EN to add the descending (DOWN) leg.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module sine_sweep_ctrl #(
  parameter int DW      = 12,
  parameter int DWELL_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  sine_sweep_ctrl_if.slave    bus
);

`ifdef SWEEP_BIDIR_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    UP   = 1'b1
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [DW-1:0]      delta_q, delta_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cfg_err_q, cfg_err_d;
  logic [DW-1:0]      stop_q, stop_d;
  logic [DW-1:0]      step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DW:0]        sum_up;
  logic [DW-1:0]      up_next;
`ifdef SWEEP_BIDIR_EN
  logic [DW-1:0]      start_q, start_d;
  logic [DW:0]        diff_dn;
  logic [DW-1:0]      dn_next;
`endif

  always_comb begin
    state_d   = state_q;
    delta_d   = delta_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
    stop_d    = stop_q;
    step_d    = step_q;
    dwell_d   = dwell_q;

    // One extra bit so the step never wraps past full scale.
    sum_up  = {1'b0, delta_q} + {1'b0, step_q};
    up_next = (sum_up > {1'b0, stop_q}) ? stop_q : sum_up[DW-1:0];
`ifdef SWEEP_BIDIR_EN
    start_d = start_q;
    diff_dn = {1'b0, delta_q} - {1'b0, step_q};
    dn_next = (diff_dn[DW] || (diff_dn[DW-1:0] < start_q)) ? start_q : diff_dn[DW-1:0];
`endif

    case (state_q)
      IDLE: begin
        if (bus.abort) begin
          delta_d = '0;
        end else if (bus.start) begin
          if ((bus.f_step == '0) || (bus.f_start > bus.f_stop)) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d = UP;
            delta_d = bus.f_start;
            cnt_d   = bus.dwell;
            busy_d  = 1'b1;
            stop_d  = bus.f_stop;
            step_d  = bus.f_step;
            dwell_d = bus.dwell;
`ifdef SWEEP_BIDIR_EN
            start_d = bus.f_start;
`endif
          end
        end
      end

      UP: begin
        if (bus.abort) begin
          state_d = IDLE;
          delta_d = '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          cnt_d = dwell_q;
          if (delta_q == stop_q) begin
`ifdef SWEEP_BIDIR_EN
            state_d = DOWN;
            delta_d = dn_next;
`else
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end else begin
            delta_d = up_next;
          end
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end

`ifdef SWEEP_BIDIR_EN
      DOWN: begin
        if (bus.abort) begin
          state_d = IDLE;
          delta_d = '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          cnt_d = dwell_q;
          if (delta_q == start_q) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            delta_d = dn_next;
          end
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      delta_q   <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      stop_q    <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
`ifdef SWEEP_BIDIR_EN
      start_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      delta_q   <= delta_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
      stop_q    <= stop_d;
      step_q    <= step_d;
      dwell_q   <= dwell_d;
`ifdef SWEEP_BIDIR_EN
      start_q   <= start_d;
`endif
    end
  end

  assign bus.delta   = delta_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.cfg_err = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sine_sweep_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_sine_sweep_ctrl
// Brief    : Self-checking bench for sine_sweep_ctrl (tone-list reference model).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_sine_sweep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sine_sweep_ctrl_if #(.DW(12), .DWELL_W(16)) bus ();

  sine_sweep_ctrl #(.DW(12), .DWELL_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int model_delta = 0;
  int tones[$];

  typedef struct {
    int fs;
    int fe;
    int st;
    int dw;
    bit err;
    int cycles;
    int final_d;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Ordered list of tones the sweep should play, from the stepping rules.
  task automatic build_model(input int fs, input int fe, input int st);
    int d;
    tones.delete();
    d = fs;
    forever begin
      tones.push_back(d);
      if (d == fe) break;
      d = d + st;
      if (d > fe) d = fe;
    end
`ifdef SWEEP_BIDIR_EN
    do begin
      d = d - st;
      if (d < fs) d = fs;
      tones.push_back(d);
    end while (d != fs);
`endif
  endtask

  task automatic run_sweep(input string nm, input int fs, input int fe, input int st,
                           input int dw, input bit exp_err, input int exp_cycles,
                           input int exp_final);
    int n;
    int per;
    int limit;
    @(negedge clk);
    bus.f_start = 12'(fs);
    bus.f_stop  = 12'(fe);
    bus.f_step  = 12'(st);
    bus.dwell   = 16'(dw);
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    // Scramble config to confirm it was captured at start.
    bus.f_start = 12'($urandom);
    bus.f_stop  = 12'($urandom);
    bus.f_step  = 12'($urandom);
    bus.dwell   = 16'($urandom_range(0, 7));
    if (exp_err) begin
      chk({nm, " cfg_err"}, int'(bus.cfg_err), 1);
      chk({nm, " err busy"}, int'(bus.busy), 0);
      chk({nm, " err delta"}, int'(bus.delta), model_delta);
      @(negedge clk);
      chk({nm, " cfg_err drop"}, int'(bus.cfg_err), 0);
      return;
    end
    chk({nm, " no cfg_err"}, int'(bus.cfg_err), 0);
    build_model(fs, fe, st);
    per   = dw + 1;
    limit = tones.size() * per;
    n     = 0;
    while (bus.busy && n < limit + 4) begin
      if (n < limit) chk({nm, " tone"}, int'(bus.delta), tones[n / per]);
      n++;
      @(negedge clk);
    end
    chk({nm, " busy cycles"}, n, exp_cycles);
    chk({nm, " done"}, int'(bus.done), 1);
    chk({nm, " final delta"}, int'(bus.delta), exp_final);
    model_delta = exp_final;
    @(negedge clk);
    chk({nm, " done drop"}, int'(bus.done), 0);
    chk({nm, " hold delta"}, int'(bus.delta), exp_final);
  endtask

  vec_t vecs[6];

  initial begin
`ifdef SWEEP_BIDIR_EN
    vecs[0] = '{10, 25, 10, 0, 1'b0, 5, 10};
    vecs[1] = '{100, 130, 10, 2, 1'b0, 21, 100};
    vecs[2] = '{7, 7, 3, 4, 1'b0, 10, 7};
    vecs[3] = '{4000, 4095, 4000, 0, 1'b0, 3, 4000};
`else
    vecs[0] = '{100, 130, 10, 2, 1'b0, 12, 130};
    vecs[1] = '{4000, 4095, 4000, 0, 1'b0, 2, 4095};
    vecs[2] = '{7, 7, 3, 4, 1'b0, 5, 7};
    vecs[3] = '{0, 4095, 4095, 0, 1'b0, 2, 4095};
`endif
    vecs[4] = '{50, 40, 10, 1, 1'b1, 0, 0};
    vecs[5] = '{50, 60, 0, 1, 1'b1, 0, 0};

    bus.start = 1'b0; bus.abort = 1'b0;
    bus.f_start = '0; bus.f_stop = '0; bus.f_step = '0; bus.dwell = '0;

    repeat (3) @(negedge clk);
    chk("reset delta", int'(bus.delta), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset cfg_err", int'(bus.cfg_err), 0);
    rst = 1'b1;
    @(negedge clk);

    // Rejected config while delta is still zero.
    run_sweep("bad_first", 50, 40, 10, 1, 1'b1, 0, 0);

    foreach (vecs[i])
      run_sweep($sformatf("vec%0d", i), vecs[i].fs, vecs[i].fe, vecs[i].st, vecs[i].dw,
                vecs[i].err, vecs[i].cycles, vecs[i].final_d);

    // Abort in second tone, with a start pulse mid-sweep that must be ignored.
    @(negedge clk);
    bus.f_start = 12'd100; bus.f_stop = 12'd130; bus.f_step = 12'd10; bus.dwell = 16'd2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("abort t0 delta", int'(bus.delta), 100);
    @(negedge clk);
    bus.f_start = 12'd999; bus.f_stop = 12'd1500; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy start ignored", int'(bus.delta), 100);
    chk("busy start busy", int'(bus.busy), 1);
    @(negedge clk);
    @(negedge clk);
    chk("abort tone2", int'(bus.delta), 110);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort delta", int'(bus.delta), 0);
    chk("abort busy", int'(bus.busy), 0);
    chk("abort no done", int'(bus.done), 0);
    @(negedge clk);
    chk("abort no done later", int'(bus.done), 0);
    chk("abort stays idle", int'(bus.busy), 0);
    model_delta = 0;

    // Abort in IDLE beats a concurrent valid start.
    run_sweep("pre_idle_abort", 100, 130, 10, 0, 1'b0,
`ifdef SWEEP_BIDIR_EN
              7, 100);
`else
              4, 130);
`endif
    @(negedge clk);
    bus.f_start = 12'd5; bus.f_stop = 12'd9; bus.f_step = 12'd1; bus.dwell = 16'd0;
    bus.abort = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0; bus.start = 1'b0;
    chk("idle abort delta", int'(bus.delta), 0);
    chk("idle abort busy", int'(bus.busy), 0);
    model_delta = 0;

    // Asynchronous reset mid-sweep, then a normal sweep.
    @(negedge clk);
    bus.f_start = 12'd100; bus.f_stop = 12'd130; bus.f_step = 12'd10; bus.dwell = 16'd2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre-reset delta", int'(bus.delta), 110);
    #1 rst = 1'b0;
    #1;
    chk("async rst delta", int'(bus.delta), 0);
    chk("async rst busy", int'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b1;
    model_delta = 0;
    run_sweep("after_rst", vecs[0].fs, vecs[0].fe, vecs[0].st, vecs[0].dw,
              1'b0, vecs[0].cycles, vecs[0].final_d);

    // Randomized sweeps against the tone-list model.
    for (int r = 0; r < 25; r++) begin
      int fs, fe, st, dw, cyc;
      bit err;
      fs = $urandom_range(0, 4095);
      fe = $urandom_range(fs, 4095);
      st = $urandom_range(1, 4095);
      if ((fe - fs) / st > 30) st = (fe - fs) / 30 + 1;
      dw = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) st = 0;
      else if ($urandom_range(0, 9) == 0 && fs != fe) begin
        int t;
        t = fs; fs = fe; fe = t;
      end
      err = (st == 0) || (fs > fe);
      cyc = 0;
      if (!err) begin
        build_model(fs, fe, st);
        cyc = tones.size() * (dw + 1);
        run_sweep($sformatf("rnd%0d", r), fs, fe, st, dw, 1'b0, cyc, tones[tones.size() - 1]);
      end else begin
        run_sweep($sformatf("rnd%0d", r), fs, fe, st, dw, 1'b1, 0, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
